dl_slp_dig_mc: RTL and testbench



---
 rtl/dl_slp_dig_mc_pkg.sv | 21 ++
 rtl/dl_slp_dig_mc_if.sv | 28 ++
 rtl/dl_slp_dig_mc_ch_scan.sv | 42 ++++
 rtl/dl_slp_dig_mc.sv | 143 ++++++++++++++
 tb/tb_dl_slp_dig_mc.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dl_slp_dig_mc_pkg.sv
// Shared FSM encoding, default sizes and channel-index width helper for the
// multi-channel dual-slope ADC controller.
package dl_slp_pkg;

    localparam int DEF_RESOLUTION = 8;
    localparam int DEF_NUM_CH     = 4;

    typedef enum logic [2:0] {
        IDLE,
        RST_INT,
        RUNUP,
        RUNDOWN,
        NEXT
    } state_t;

    // Channel index needs at least one bit even for a single channel.
    function automatic int ch_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dl_slp_dig_mc_if.sv
// Bus-side port group of the dual-slope controller: scan request in, results out.
interface dl_slp_dig_mc_if #(
    parameter int RESOLUTION = dl_slp_pkg::DEF_RESOLUTION,
    parameter int NUM_CH     = dl_slp_pkg::DEF_NUM_CH
);
    import dl_slp_pkg::*;

    localparam int CH_W = ch_w(NUM_CH);

    logic                  start;
    logic [NUM_CH-1:0]     ch_mask;
    logic [RESOLUTION-1:0] dig_out;
    logic [CH_W-1:0]       dig_ch;
    logic                  eoc;
    logic                  ovf;
    logic                  busy;

    modport master (
        output start, ch_mask,
        input  dig_out, dig_ch, eoc, ovf, busy
    );

    modport slave (
        input  start, ch_mask,
        output dig_out, dig_ch, eoc, ovf, busy
    );

endinterface

// File: rtl/dl_slp_dig_mc_ch_scan.sv
// Channel scanner: holds the latched channel mask, points at its lowest set bit
// and retires that bit when the current channel is finished.
module dl_slp_ch_scan
    import dl_slp_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CH_W   = ch_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [NUM_CH-1:0] mask_in,
    input  logic              clr,
    output logic [CH_W-1:0]   cur,
    output logic              more
);

    logic [NUM_CH-1:0] mask;
    logic [NUM_CH-1:0] rest;

    always_ff @(posedge clk) begin
        if (rst) begin
            mask <= '0;
        end else if (load) begin
            mask <= mask_in;
        end else if (clr) begin
            mask <= rest;
        end
    end

    // Scanning downward lets the lowest set bit win.
    always_comb begin
        cur = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) cur = CH_W'(i);
        end
    end

    assign rest = mask & ~(NUM_CH'(1) << cur);
    assign more = |rest;

endmodule

// File: rtl/dl_slp_dig_mc.sv
// Multi-channel dual-slope ADC sequencer: integrator reset, fixed run-up and timed
// run-down per enabled channel. Define DL_SLP_AVG_EN to average 2^AVG_LOG2 conversions.
module dl_slp_dig_mc
    import dl_slp_pkg::*;
#(
    parameter int RESOLUTION = DEF_RESOLUTION,
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int RST_CYC    = 4,
    parameter int AVG_LOG2   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    dl_slp_dig_mc_if.slave          bus,
    input  logic                    cmp_out,
    output logic                    integrator_rstn,
    output logic                    integrator_sel,
    output logic [ch_w(NUM_CH)-1:0] ch_sel
);

    localparam int CH_W  = ch_w(NUM_CH);
    localparam int CNT_W = RESOLUTION + 1;
    localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] RUNUP_LAST = CNT_W'((1 << RESOLUTION) - 1);
    localparam logic [CNT_W-1:0] CODE_MAX   = CNT_W'((1 << RESOLUTION) - 1);

    state_t                state;
    state_t                state_nx;
    logic [CNT_W-1:0]      cnt;
    logic [CH_W-1:0]       cur_ch;
    logic                  more;
    logic                  load;
    logic                  rd_done;
    logic                  rd_ovf;
    logic                  last_conv;
    logic [RESOLUTION-1:0] rd_code;
    logic [RESOLUTION-1:0] res_code;
    logic                  res_ovf;

    assign load = (state == IDLE) && bus.start && (|bus.ch_mask);

    dl_slp_ch_scan #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_scan (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .mask_in (bus.ch_mask),
        .clr     (state == NEXT),
        .cur     (cur_ch),
        .more    (more)
    );

    assign ch_sel          = cur_ch;
    assign integrator_rstn = (state == RUNUP) || (state == RUNDOWN);
    assign integrator_sel  = (state == RUNDOWN);
    assign bus.busy        = (state != IDLE);

    // Run-down ends when the comparator falls, or saturates at full scale while still high.
    assign rd_ovf  = cmp_out && (cnt == CODE_MAX);
    assign rd_done = !cmp_out || rd_ovf;
    assign rd_code = rd_ovf ? '1 : cnt[RESOLUTION-1:0];

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (load) state_nx = RST_INT;
            RST_INT: if (cnt == RST_LAST) state_nx = RUNUP;
            RUNUP:   if (cnt == RUNUP_LAST) state_nx = RUNDOWN;
            RUNDOWN: if (rd_done) state_nx = last_conv ? NEXT : RST_INT;
            NEXT:    state_nx = more ? RST_INT : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Each phase counts from zero; the counter only advances while a phase is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (state_nx != state) begin
                cnt <= '0;
            end else if ((state == RST_INT) || (state == RUNUP) || (state == RUNDOWN)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef DL_SLP_AVG_EN
    localparam int ACC_W  = RESOLUTION + AVG_LOG2;
    localparam int CONV_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_sum;
    logic [CONV_W-1:0] conv;
    logic              ovf_acc;

    assign acc_sum   = acc + ACC_W'(rd_code);
    assign last_conv = (conv == CONV_W'((1 << AVG_LOG2) - 1));
    assign res_code  = acc_sum[ACC_W-1:AVG_LOG2];
    assign res_ovf   = ovf_acc | rd_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            conv    <= '0;
            ovf_acc <= 1'b0;
        end else if ((state == RUNDOWN) && rd_done) begin
            if (last_conv) begin
                acc     <= '0;
                conv    <= '0;
                ovf_acc <= 1'b0;
            end else begin
                acc     <= acc_sum;
                conv    <= conv + 1'b1;
                ovf_acc <= res_ovf;
            end
        end
    end
`else
    // Without averaging every conversion finishes its channel.
    assign last_conv = (AVG_LOG2 >= 0);
    assign res_code  = rd_code;
    assign res_ovf   = rd_ovf;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.dig_out <= '0;
            bus.dig_ch  <= '0;
            bus.ovf     <= 1'b0;
            bus.eoc     <= 1'b0;
        end else begin
            bus.eoc <= 1'b0;
            if ((state == RUNDOWN) && rd_done && last_conv) begin
                bus.dig_out <= res_code;
                bus.dig_ch  <= ch_sel;
                bus.ovf     <= res_ovf;
                bus.eoc     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dl_slp_dig_mc.sv
// Scoreboard bench for dl_slp_dig_mc: a comparator model plays planned run-down
// codes, expected results are queued at scan issue and checked on every eoc.
module tb_dl_slp_dig_mc;
    import dl_slp_pkg::*;

    localparam int RESOLUTION = 8;
    localparam int NUM_CH     = 4;
    localparam int RST_CYC    = 4;
    localparam int AVG_LOG2   = 2;
    localparam int CH_W       = ch_w(NUM_CH);
    localparam int FULL       = (1 << RESOLUTION) - 1;
`ifdef DL_SLP_AVG_EN
    localparam int NCONV = 1 << AVG_LOG2;
`else
    localparam int NCONV = 1;
`endif

    typedef struct {
        int ch;
        int code;
        bit ovf;
    } exp_t;

    logic            clk     = 1'b0;
    logic            rst     = 1'b1;
    logic            cmp_out = 1'b0;
    logic            integrator_rstn;
    logic            integrator_sel;
    logic [CH_W-1:0] ch_sel;

    dl_slp_dig_mc_if #(.RESOLUTION(RESOLUTION), .NUM_CH(NUM_CH)) bus ();

    dl_slp_dig_mc #(
        .RESOLUTION (RESOLUTION),
        .NUM_CH     (NUM_CH),
        .RST_CYC    (RST_CYC),
        .AVG_LOG2   (AVG_LOG2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .cmp_out         (cmp_out),
        .integrator_rstn (integrator_rstn),
        .integrator_sel  (integrator_sel),
        .ch_sel          (ch_sel)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   code_q[$];
    int   chsel_q[$];
    int   codes_in[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Comparator model: stays high for exactly 'code' run-down cycles, then falls.
    int rd_code  = 0;
    int rd_k     = 0;
    bit prev_sel = 1'b0;
    always @(negedge clk) begin
        if (integrator_sel) begin
            if (!prev_sel) begin
                rd_k = 0;
                check("rundown_expected", int'(code_q.size() > 0), 1);
                rd_code = (code_q.size() > 0) ? code_q.pop_front() : 0;
                if (chsel_q.size() > 0) check("ch_sel", int'(ch_sel), chsel_q.pop_front());
            end
            cmp_out = (rd_k < rd_code);
            rd_k++;
        end else begin
            cmp_out = 1'($urandom_range(0, 1));
        end
        prev_sel = integrator_sel;
    end

    bit prev_eoc = 1'b0;
    always @(negedge clk) begin
        if (bus.eoc) begin
            exp_t e;
            check("eoc_not_back_to_back", int'(prev_eoc), 0);
            check("eoc_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("dig_out", int'(bus.dig_out), e.code);
                check("dig_ch", int'(bus.dig_ch), e.ch);
                check("ovf", int'(bus.ovf), int'(e.ovf));
            end
        end
        prev_eoc = bus.eoc;
    end

    function automatic int rand_code();
        if ($urandom_range(0, 7) == 0) return 1000;
        return int'($urandom_range(0, FULL - 1));
    endfunction

    task automatic plan_fixed(input logic [NUM_CH-1:0] mask, input int code);
        for (int ch = 0; ch < NUM_CH; ch++)
            if (mask[ch]) for (int k = 0; k < NCONV; k++) codes_in.push_back(code);
    endtask

    task automatic plan_random(input logic [NUM_CH-1:0] mask);
        for (int ch = 0; ch < NUM_CH; ch++)
            if (mask[ch]) for (int k = 0; k < NCONV; k++) codes_in.push_back(rand_code());
    endtask

    // Expected result per channel: saturated code per conversion, averaged by truncation.
    task automatic issue(input logic [NUM_CH-1:0] mask);
        int   sum;
        bit   ov;
        int   c;
        exp_t e;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (mask[ch]) begin
                sum = 0;
                ov  = 1'b0;
                for (int k = 0; k < NCONV; k++) begin
                    c = (codes_in.size() > 0) ? codes_in.pop_front() : 0;
                    code_q.push_back(c);
                    chsel_q.push_back(ch);
                    sum += (c > FULL) ? FULL : c;
                    ov  |= (c > FULL);
                end
                e.ch   = ch;
                e.code = sum / NCONV;
                e.ovf  = ov;
                exp_q.push_back(e);
            end
        end
        bus.ch_mask = mask;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.ch_mask = NUM_CH'($urandom);
        check("busy_after_start", int'(bus.busy), int'(mask != '0));
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((bus.busy || exp_q.size() != 0) && n < budget) begin
            if (bus.busy) begin
                bus.start   = ($urandom_range(0, 40) == 0);
                bus.ch_mask = NUM_CH'($urandom);
            end
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        check("scan_done_in_budget", int'(n < budget), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int n;
        bus.start   = 1'b0;
        bus.ch_mask = '0;
        rst         = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_integrator_rstn", int'(integrator_rstn), 0);
        check("rst_integrator_sel", int'(integrator_sel), 0);
        check("rst_ch_sel", int'(ch_sel), 0);
        check("rst_dig_out", int'(bus.dig_out), 0);
        check("rst_dig_ch", int'(bus.dig_ch), 0);
        check("rst_eoc", int'(bus.eoc), 0);
        check("rst_ovf", int'(bus.ovf), 0);
        check("rst_busy", int'(bus.busy), 0);
        rst = 1'b0;
        @(negedge clk);

        // Single channel, code 100: eoc latency counted in edges after the start edge.
        plan_fixed(4'b0001, 100);
        issue(4'b0001);
        e = 0;
        while (!bus.eoc && e < 5000) begin
            @(negedge clk);
            e++;
        end
        check("eoc_latency", e, NCONV * (RST_CYC + (1 << RESOLUTION) + 100 + 1));
        @(negedge clk);
        check("busy_after_eoc", int'(bus.busy), 0);
        wait_idle(20000);

        plan_fixed(4'b0001, 1000);
        issue(4'b0001);
        wait_idle(20000);

        plan_fixed(4'b0001, 0);
        issue(4'b0001);
        wait_idle(20000);

        plan_fixed(4'b0010, 30);
        plan_fixed(4'b1000, 200);
        issue(4'b1010);
        wait_idle(20000);

        issue(4'b0000);
        repeat (5) @(negedge clk);
        check("empty_mask_ignored", int'(bus.busy), 0);

        // Reset in the middle of run-up discards the scan.
        plan_fixed(4'b0110, 50);
        issue(4'b0110);
        n = 0;
        while (!(integrator_rstn && !integrator_sel) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reached_runup", int'(n < 100), 1);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_integrator_rstn", int'(integrator_rstn), 0);
        check("midrst_integrator_sel", int'(integrator_sel), 0);
        check("midrst_ch_sel", int'(ch_sel), 0);
        check("midrst_dig_out", int'(bus.dig_out), 0);
        check("midrst_dig_ch", int'(bus.dig_ch), 0);
        check("midrst_eoc", int'(bus.eoc), 0);
        check("midrst_ovf", int'(bus.ovf), 0);
        check("midrst_busy", int'(bus.busy), 0);
        exp_q.delete();
        code_q.delete();
        chsel_q.delete();
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_stays_idle", int'(bus.busy), 0);

        plan_fixed(4'b0100, 77);
        issue(4'b0100);
        wait_idle(20000);

`ifdef DL_SLP_AVG_EN
        for (int k = 10; k <= 13; k++) codes_in.push_back(k);
        issue(4'b0100);
        wait_idle(20000);
`endif

        for (int s = 0; s < 5; s++) begin
            logic [NUM_CH-1:0] m;
            m = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
            plan_random(m);
            issue(m);
            wait_idle(20000);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
